// File: rtl/kband_arrow_packer.sv
// -----------------------------------------------------------------------------
// kband_arrow_packer
//
// Packs narrow arrow/direction beats from the K-band affine alignment array
// into 128-bit lines and writes them to consecutive addresses of the
// single-port arrow memory. A partial final line is written with byte enables
// that cover only its filled lanes. The block also reports how many lines the
// run stored.
//
// Optional feature: KBAND_PACKER_OVERFLOW_STALL_EN
//   defined   - a run that would write past line DEPTH-1 stops accepting beats
//               after the line at DEPTH-1 is written. The block then holds
//               until reset.
//   undefined - the pointer wraps to 0 and older lines are overwritten.
//   Both builds set the sticky overflow flag.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, base_addr  run start pulse (IDLE only) and first line address
//   in_data/in_valid/in_last/in_ready   beat stream (valid/ready handshake)
//   mem_*             memory write port (chipselect == write, clken == 1)
//   words_written     lines written this run
//   done              one-cycle end-of-run pulse
//   overflow          sticky, set by a write from line DEPTH-1
// -----------------------------------------------------------------------------
module kband_arrow_packer #(
   parameter int IN_W   = 32,
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [IN_W-1:0]   in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [127:0]      mem_writedata,
   output logic [15:0]       mem_byteenable,
   output logic              mem_clken,
   output logic [ADDR_W:0]   words_written,
   output logic              done,
   output logic              overflow
);

   localparam int LANES = 128 / IN_W;
   localparam int BPL   = IN_W / 8;
   localparam int LC_W  = $clog2(LANES);
   localparam int WW_W  = ADDR_W + 1;
   localparam logic [LC_W-1:0]   LAST_LANE = LC_W'(LANES - 1);
   localparam logic [ADDR_W-1:0] PTR_MAX   = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [LC_W-1:0]     lane_q, lane_d;
   logic [127:0]        line_q, line_d;
   logic                rdy_q, rdy_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [127:0]        data_q, data_d;
   logic [15:0]         be_q, be_d;
   logic [WW_W-1:0]     words_q, words_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;

   logic [127:0]        line_ins_s;
   logic [15:0]         be_part_s;
   logic [ADDR_W-1:0]   ptr_inc_s;
   logic                issue_s;
   logic [127:0]        issue_data_s;
   logic [15:0]         issue_be_s;

   // Next-state logic: beat packing, line issue, pointer/flag bookkeeping
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      lane_d       = lane_q;
      line_d       = line_q;
      rdy_d        = rdy_q;
      wr_d         = 1'b0;
      addr_d       = addr_q;
      data_d       = data_q;
      be_d         = be_q;
      words_d      = words_q;
      done_d       = 1'b0;
      ovf_d        = ovf_q;
      issue_s      = 1'b0;
      issue_data_s = 128'd0;
      issue_be_s   = 16'd0;
      line_ins_s   = line_q;
      be_part_s    = 16'd0;

      // Current line with the incoming beat dropped into lane lane_q
      for (int i = 0; i < LANES; i++) begin
         if (lane_q == LC_W'(i)) begin
            line_ins_s[i*IN_W +: IN_W] = in_data;
         end else begin
            line_ins_s[i*IN_W +: IN_W] = line_q[i*IN_W +: IN_W];
         end
      end

      // Byte enables for the lanes already filled (lanes below lane_q)
      for (int i = 0; i < LANES; i++) begin
         if (LC_W'(i) < lane_q) begin
            be_part_s[i*BPL +: BPL] = {BPL{1'b1}};
         end else begin
            be_part_s[i*BPL +: BPL] = {BPL{1'b0}};
         end
      end

      if (ptr_q == PTR_MAX) begin
         ptr_inc_s = {ADDR_W{1'b0}};
      end else begin
         ptr_inc_s = ptr_q + ADDR_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            rdy_d = 1'b0;
            if (start) begin
               state_d = S_RUN;
               ptr_d   = base_addr;
               lane_d  = {LC_W{1'b0}};
               line_d  = 128'd0;
               words_d = {WW_W{1'b0}};
               ovf_d   = 1'b0;
               rdy_d   = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (in_valid && rdy_q) begin
               if (lane_q == LAST_LANE) begin
                  issue_s      = 1'b1;
                  issue_data_s = line_ins_s;
                  issue_be_s   = 16'hFFFF;
                  lane_d       = {LC_W{1'b0}};
                  line_d       = 128'd0;
`ifdef KBAND_PACKER_OVERFLOW_STALL_EN
                  // Further beats would overwrite line 0: stop accepting.
                  if (!in_last && (ptr_q == PTR_MAX)) begin
                     rdy_d = 1'b0;
                  end else begin
                     rdy_d = rdy_q;
                  end
`endif
               end else begin
                  lane_d = lane_q + LC_W'(1);
                  line_d = line_ins_s;
               end
               if (in_last) begin
                  state_d = S_FLUSH;
                  rdy_d   = 1'b0;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_FLUSH: begin
            state_d = S_DONE;
            if (lane_q != {LC_W{1'b0}}) begin
               issue_s      = 1'b1;
               issue_data_s = line_q;
               issue_be_s   = be_part_s;
               lane_d       = {LC_W{1'b0}};
               line_d       = 128'd0;
            end else begin
               // Last write already issued with the completing beat.
               done_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            // done_q set means the pulse came from FLUSH; otherwise the
            // partial write is issuing now and done follows it.
            if (done_q) begin
               done_d = 1'b0;
            end else begin
               done_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            rdy_d   = 1'b0;
         end
      endcase

      // Register a line for writing on the next cycle and advance the pointer
      if (issue_s) begin
         wr_d    = 1'b1;
         addr_d  = ptr_q;
         data_d  = issue_data_s;
         be_d    = issue_be_s;
         ptr_d   = ptr_inc_s;
         words_d = words_q + WW_W'(1);
         if (ptr_q == PTR_MAX) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_q;
         end
      end else begin
         wr_d = 1'b0;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= {ADDR_W{1'b0}};
         lane_q  <= {LC_W{1'b0}};
         line_q  <= 128'd0;
         rdy_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         data_q  <= 128'd0;
         be_q    <= 16'd0;
         words_q <= {WW_W{1'b0}};
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lane_q  <= lane_d;
         line_q  <= line_d;
         rdy_q   <= rdy_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         be_q    <= be_d;
         words_q <= words_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   // A write strobe that meets a reset cycle is suppressed.
   assign mem_write      = wr_q & ~reset;
   assign mem_chipselect = wr_q & ~reset;
   assign mem_address    = addr_q;
   assign mem_writedata  = data_q;
   assign mem_byteenable = be_q;
   assign mem_clken      = 1'b1;
   assign in_ready       = rdy_q;
   assign words_written  = words_q;
   assign done           = done_q;
   assign overflow       = ovf_q;

endmodule
